// File: rtl/iterative_subtract_divider.sv
// Restoring divider for signed and unsigned integer division.
// It produces one quotient bit per clock. Divide-by-zero and signed
// overflow are resolved in the same cycle that the operands are accepted.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for operands; in_ready_o high
// S_BUSY | one trial subtraction per edge, WIDTH edges in total
// S_DONE | result held on q_o/r_o until the consumer takes it
module iterative_subtract_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero, ovf;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic             last_step;

  // Decode operands at the accept edge: magnitudes and the two special cases.
  always_comb begin
    a_mag  = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    b_mag  = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
    b_zero = (b_i == '0);
    ovf    = signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
  end

  // One restoring step. Before the shift the partial remainder is always
  // below 2^(k) after k steps, so the top bit of rem_sh is zero and the
  // subtraction matches a {1'b0, rem'} - {1'b0, divisor} trial.
  always_comb begin
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_sh - {1'b0, div_q};
    step_quo  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    step_rem  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    q_d     = q_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (b_zero) begin
            q_d     = '1;
            r_d     = a_i;
            state_d = S_DONE;
          end else if (ovf) begin
            q_d     = a_i;
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            quo_d   = a_mag;
            div_d   = b_mag;
            negq_d  = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            negr_d  = signed_i && a_i[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          q_d     = negq_q ? (~step_quo + 1'b1) : step_quo;
          r_d     = negr_q ? (~step_rem + 1'b1) : step_rem;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign q_o         = q_q;
  assign r_o         = r_q;

endmodule

// File: tb/tb_iterative_subtract_divider.sv
// Scoreboard bench for iterative_subtract_divider (WIDTH=32).
module tb_iterative_subtract_divider;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        signed_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] q_o;
  logic [31:0] r_o;

  iterative_subtract_divider #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .q_o(q_o), .r_o(r_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   seen = 1'b0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each result on its first cycle of out_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i || !out_valid_o) begin
        seen = 1'b0;
      end else if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual q=%0h r=%0h required none", q_o, r_o);
        end else begin
          e = sb.pop_front();
          chk("quotient", q_o, e.q);
          chk("remainder", r_o, e.r);
          chk("latency_edges", 32'(edge_cnt - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL wait_in_ready actual=timeout required=in_ready");
    end
  endtask

  // Issue one operation; lat is edges after the accept edge until out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input int lat);
    exp_t e;
    wait_idle();
    a_i = a;
    b_i = b;
    signed_i = s;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    e.q = eq;
    e.r = er;
    e.lat = lat;
    e.acc = edge_cnt;
    sb.push_back(e);
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] eq, er;
    int lat;
    lat = 32;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = a; er = 32'd0; lat = 0;
    end else if (s) begin
      eq = $signed(a) / $signed(b);
      er = $signed(a) % $signed(b);
    end else begin
      eq = a / b;
      er = a % b;
    end
    issue(a, b, s, eq, er, lat);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int n;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("reset_q", q_o, 32'd0);
    chk("reset_r", r_o, 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 32);
    issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 32);
    issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 0);
    issue(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 32);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 32);

    // Backpressure: hold the result for 5 cycles while new operands are offered.
    wait_idle();
    out_ready_i = 1'b0;
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      a_i = 32'd1;
      b_i = 32'd1;
      in_valid_i = 1'b1;
      chk("bp_out_valid", {31'd0, out_valid_o}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("bp_q", q_o, 32'd14);
      chk("bp_r", r_o, 32'd2);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("release_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("idle_q_held", q_o, 32'd14);
    in_valid_i = 1'b0;

    // Reset in the middle of BUSY drops the operation.
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);
    repeat (9) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("abort_q", q_o, 32'd0);
    chk("abort_r", r_o, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 32);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      issue_model(ra, rb, 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
